// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encodings and mode constants for the stopwatch
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_COUNTING = 2'b01,
        ST_PAUSED   = 2'b10,
        ST_DONE     = 2'b11
    } sw_state_e;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/stopwatch_lap_ctl_if.sv
// rtl/stopwatch_lap_ctl_if.sv - command/status bundle between a controller host and the stopwatch
interface stopwatch_lap_ctl_if #(
    parameter int TIME_W    = 16,
    parameter int LAP_DEPTH = 4
);
    logic                         trig;
    logic                         split;
    logic                         tick;
    logic                         mode;
    logic [TIME_W-1:0]            load_val;
    logic                         rd_next;
    logic [TIME_W-1:0]            time_val;
    logic [1:0]                   state;
    logic                         done;
    logic [TIME_W-1:0]            lap_val;
    logic [$clog2(LAP_DEPTH):0]   lap_cnt;
    logic                         lap_full;
    logic                         lap_empty;

    modport master (
        output trig, split, tick, mode, load_val, rd_next,
        input  time_val, state, done, lap_val, lap_cnt, lap_full, lap_empty
    );

    modport slave (
        input  trig, split, tick, mode, load_val, rd_next,
        output time_val, state, done, lap_val, lap_cnt, lap_full, lap_empty
    );
endinterface

// File: rtl/lap_fifo.sv
// rtl/lap_fifo.sv - first-word fall-through lap buffer with clear, drop-on-full push
module lap_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees a slot, so a push into a full buffer is still accepted.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data;
    end

    assign count = cnt_q;
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/stopwatch_lap_ctl.sv
// rtl/stopwatch_lap_ctl.sv - up/down stopwatch FSM with lap capture buffer
module stopwatch_lap_ctl
    import stopwatch_pkg::*;
#(
    parameter int TIME_W    = 16,
    parameter int LAP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    stopwatch_lap_ctl_if.slave   bus
);
    localparam logic [TIME_W-1:0] TIME_MAX = '1;

    sw_state_e          state_q, state_d;
    logic [TIME_W-1:0]  time_q, time_d;
    logic               mode_q, mode_d;
    logic               done_q;
    logic               push;
    logic               clr;

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        mode_d  = mode_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                time_d = (bus.mode == MODE_DOWN) ? bus.load_val : '0;
                if (bus.trig) begin
                    mode_d  = bus.mode;
                    state_d = (bus.mode == MODE_DOWN && bus.load_val == '0) ? ST_DONE : ST_COUNTING;
                end
            end
            ST_COUNTING: begin
                // trig outranks both split and tick: time stays put and no lap is taken.
                if (bus.trig) begin
                    state_d = ST_PAUSED;
                end else begin
                    push = bus.split;
                    if (bus.tick) begin
                        if (mode_q == MODE_UP) begin
                            time_d = (time_q == TIME_MAX) ? time_q : time_q + TIME_W'(1);
                        end else begin
                            time_d = (time_q == '0) ? '0 : time_q - TIME_W'(1);
                            if (time_q <= TIME_W'(1)) state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_PAUSED: begin
                if (bus.trig)       state_d = ST_COUNTING;
                else if (bus.split) state_d = ST_IDLE;
            end
            ST_DONE: begin
                if (bus.trig || bus.split) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign clr = (state_d == ST_IDLE) && (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            mode_q  <= MODE_UP;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            mode_q  <= mode_d;
            done_q  <= (state_d == ST_DONE);
        end
    end

    lap_fifo #(
        .WIDTH (TIME_W),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .push  (push),
        .data  (time_q),
        .pop   (bus.rd_next),
        .head  (bus.lap_val),
        .count (bus.lap_cnt),
        .full  (bus.lap_full),
        .empty (bus.lap_empty)
    );

    assign bus.time_val = time_q;
    assign bus.state    = state_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_stopwatch_lap_ctl.sv
// tb/tb_stopwatch_lap_ctl.sv - scoreboard bench for stopwatch_lap_ctl
module tb_stopwatch_lap_ctl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [15:0] lap_q[$];
    logic [15:0] exp_lap;

    stopwatch_lap_ctl_if #(.TIME_W(16), .LAP_DEPTH(4)) b ();
    stopwatch_lap_ctl_if #(.TIME_W(4),  .LAP_DEPTH(4)) b4 ();

    stopwatch_lap_ctl #(.TIME_W(16), .LAP_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b.slave)
    );

    stopwatch_lap_ctl #(.TIME_W(4), .LAP_DEPTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_trig();
        b.trig = 1'b1;
        step();
        b.trig = 1'b0;
    endtask

    task automatic pulse_split();
        b.split = 1'b1;
        step();
        b.split = 1'b0;
    endtask

    task automatic drain_laps(input string tag);
        while (lap_q.size() > 0) begin
            exp_lap = lap_q.pop_front();
            check_eq({tag, "_head"}, b.lap_val, exp_lap);
            b.rd_next = 1'b1;
            step();
            b.rd_next = 1'b0;
        end
        check_eq({tag, "_empty"}, b.lap_empty, 1);
        check_eq({tag, "_val0"}, b.lap_val, 0);
        check_eq({tag, "_cnt0"}, b.lap_cnt, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        {b.trig, b.split, b.tick, b.mode, b.rd_next} = '0;
        b.load_val = '0;
        {b4.trig, b4.split, b4.tick, b4.mode, b4.rd_next} = '0;
        b4.load_val = '0;
        reset = 1'b1;
        step();
        step();
        check_eq("rst_state", b.state, 0);
        check_eq("rst_time", b.time_val, 0);
        check_eq("rst_done", b.done, 0);
        check_eq("rst_cnt", b.lap_cnt, 0);
        check_eq("rst_empty", b.lap_empty, 1);
        check_eq("rst_full", b.lap_full, 0);
        check_eq("rst_lapval", b.lap_val, 0);
        reset = 1'b0;
        step();

        // up count, pause freezes time
        pulse_trig();
        check_eq("up_run_state", b.state, 1);
        b.tick = 1'b1;
        repeat (5) step();
        b.tick = 1'b0;
        pulse_trig();
        check_eq("up_pause_state", b.state, 2);
        check_eq("up_pause_time", b.time_val, 5);
        b.tick = 1'b1;
        repeat (3) step();
        b.tick = 1'b0;
        check_eq("up_frozen_time", b.time_val, 5);

        // trig and split together: trig wins, no lap
        pulse_trig();
        b.trig = 1'b1; b.split = 1'b1; b.tick = 1'b1;
        step();
        b.trig = 1'b0; b.split = 1'b0; b.tick = 1'b0;
        check_eq("tie_state", b.state, 2);
        check_eq("tie_cnt", b.lap_cnt, 0);
        check_eq("tie_time", b.time_val, 5);
        pulse_split();
        check_eq("paused_split_state", b.state, 0);

        // down count to DONE
        b.mode = 1'b1;
        b.load_val = 16'd3;
        step();
        check_eq("dn_idle_load", b.time_val, 3);
        pulse_trig();
        check_eq("dn_run_state", b.state, 1);
        b.tick = 1'b1;
        repeat (2) step();
        check_eq("dn_mid_time", b.time_val, 1);
        step();
        b.tick = 1'b0;
        check_eq("dn_zero_time", b.time_val, 0);
        check_eq("dn_done_state", b.state, 3);
        check_eq("dn_done_flag", b.done, 1);
        pulse_split();
        check_eq("dn_back_idle", b.state, 0);
        check_eq("dn_idle_doneflag", b.done, 0);
        step();
        check_eq("dn_reload", b.time_val, 3);

        // load_val of zero goes straight to DONE
        b.load_val = '0;
        step();
        pulse_trig();
        check_eq("dn0_state", b.state, 3);
        check_eq("dn0_done", b.done, 1);
        pulse_trig();
        check_eq("dn0_idle", b.state, 0);
        b.mode = 1'b0;
        step();

        // fill lap buffer past full; overflowing push dropped
        pulse_trig();
        for (int i = 1; i <= 5; i++) begin
            b.tick = 1'b1;
            step();
            b.tick = 1'b0;
            if (lap_q.size() < 4) lap_q.push_back(16'(i));
            pulse_split();
            check_eq($sformatf("fill_cnt%0d", i), b.lap_cnt, lap_q.size());
        end
        check_eq("fill_full", b.lap_full, 1);
        drain_laps("drain1");
        b.rd_next = 1'b1;
        step();
        b.rd_next = 1'b0;
        check_eq("pop_empty_cnt", b.lap_cnt, 0);

        // split with tick captures pre-update time
        for (int i = 5; i <= 8; i++) begin
            lap_q.push_back(16'(i));
            b.tick = 1'b1; b.split = 1'b1;
            step();
            b.tick = 1'b0; b.split = 1'b0;
        end
        check_eq("refill_time", b.time_val, 9);
        check_eq("refill_full", b.lap_full, 1);
        exp_lap = lap_q.pop_front();
        check_eq("pushpop_head", b.lap_val, exp_lap);
        lap_q.push_back(16'd9);
        b.split = 1'b1; b.rd_next = 1'b1;
        step();
        b.split = 1'b0; b.rd_next = 1'b0;
        check_eq("pushpop_cnt", b.lap_cnt, 4);
        check_eq("pushpop_full", b.lap_full, 1);
        drain_laps("drain2");

        // reset mid-count with laps stored
        pulse_split();
        b.tick = 1'b1;
        step();
        b.tick = 1'b0;
        pulse_split();
        check_eq("pre_rst_cnt", b.lap_cnt, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        lap_q.delete();
        check_eq("midrst_state", b.state, 0);
        check_eq("midrst_time", b.time_val, 0);
        check_eq("midrst_cnt", b.lap_cnt, 0);
        step();

        // leaving PAUSED for IDLE clears laps
        pulse_trig();
        pulse_split();
        check_eq("pclr_cnt1", b.lap_cnt, 1);
        pulse_trig();
        pulse_split();
        check_eq("pclr_state", b.state, 0);
        check_eq("pclr_cnt0", b.lap_cnt, 0);

        // narrow counter saturates
        b4.trig = 1'b1;
        step();
        b4.trig = 1'b0;
        b4.tick = 1'b1;
        repeat (20) step();
        b4.tick = 1'b0;
        check_eq("sat_time", b4.time_val, 15);
        check_eq("sat_state", b4.state, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
